// File: rtl/sw_event_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : sw_event_gen                                                       |
// | Brief  : Push-button conditioner: sync, debounce, press/release/step/long.  |
// | Rev    : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
module sw_event_gen #(
    parameter int DEB_CNT    = 500000,
    parameter int LONG_CNT   = 50000000,
    parameter int RPT_CNT    = 10000000,
    parameter bit SW_ACT_LOW = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sw,
    output logic o_sw_lvl,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_step
);

    localparam logic [31:0] c_deb_last  = 32'(DEB_CNT - 1);
    localparam logic [31:0] c_long_last = 32'(LONG_CNT - 1);
    localparam logic [31:0] c_rpt_last  = 32'(RPT_CNT - 1);
    localparam logic        c_sw_idle   = SW_ACT_LOW;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic        r_s1;
    logic        r_s2;
    logic        r_stable;
    logic [31:0] r_deb_cnt;

    logic        w_s2_pressed;
    logic        w_mismatch;
    logic        w_accept;
    logic        w_rise;
    logic        w_fall;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_hold_cnt;
    logic [31:0] w_hold_nxt;
    logic [31:0] r_rpt_cnt;
    logic [31:0] w_rpt_nxt;
    logic        r_long;
    logic        w_long_nxt;
    logic        r_press;
    logic        w_press_nxt;
    logic        r_release;
    logic        w_release_nxt;
    logic        r_step;
    logic        w_step_nxt;

    // Internally pressed = 1 regardless of the button wiring.
    assign w_s2_pressed = r_s2 ^ c_sw_idle;
    assign w_mismatch   = (w_s2_pressed != r_stable);
    assign w_accept     = w_mismatch && (r_deb_cnt == c_deb_last);
    // Edge strobes fire in the cycle before r_stable updates, so the FSM
    // outputs register on the same edge as the debounced level.
    assign w_rise       = w_accept && w_s2_pressed;
    assign w_fall       = w_accept && !w_s2_pressed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1      <= c_sw_idle;
            r_s2      <= c_sw_idle;
            r_stable  <= 1'b0;
            r_deb_cnt <= 32'd0;
        end else begin
            r_s1 <= i_sw;
            r_s2 <= r_s1;
            if (!w_mismatch) begin
                r_deb_cnt <= 32'd0;
            end else if (w_accept) begin
                r_stable  <= w_s2_pressed;
                r_deb_cnt <= 32'd0;
            end else begin
                r_deb_cnt <= r_deb_cnt + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= 32'd0;
            r_rpt_cnt  <= 32'd0;
            r_long     <= 1'b0;
            r_press    <= 1'b0;
            r_release  <= 1'b0;
            r_step     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_rpt_cnt  <= w_rpt_nxt;
            r_long     <= w_long_nxt;
            r_press    <= w_press_nxt;
            r_release  <= w_release_nxt;
            r_step     <= w_step_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_hold_nxt    = r_hold_cnt;
        w_rpt_nxt     = r_rpt_cnt;
        w_long_nxt    = r_long;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_step_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_HELD;
                    w_hold_nxt  = 32'd0;
                    w_press_nxt = 1'b1;
                    w_step_nxt  = 1'b1;
                end
            end
            ST_HELD: begin
                // Release is tested first so it wins over the long-press point.
                if (w_fall) begin
                    w_state_nxt   = ST_IDLE;
                    w_hold_nxt    = 32'd0;
                    w_rpt_nxt     = 32'd0;
                    w_long_nxt    = 1'b0;
                    w_release_nxt = 1'b1;
                end else if (r_hold_cnt == c_long_last) begin
                    w_state_nxt = ST_REPEAT;
                    w_hold_nxt  = 32'd0;
                    w_rpt_nxt   = 32'd0;
                    w_long_nxt  = 1'b1;
                    w_step_nxt  = 1'b1;
                end else begin
                    w_hold_nxt = r_hold_cnt + 32'd1;
                end
            end
            ST_REPEAT: begin
                if (w_fall) begin
                    w_state_nxt   = ST_IDLE;
                    w_hold_nxt    = 32'd0;
                    w_rpt_nxt     = 32'd0;
                    w_long_nxt    = 1'b0;
                    w_release_nxt = 1'b1;
                end else if (r_rpt_cnt == c_rpt_last) begin
                    w_rpt_nxt  = 32'd0;
                    w_step_nxt = 1'b1;
                end else begin
                    w_rpt_nxt = r_rpt_cnt + 32'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_hold_nxt  = 32'd0;
                w_rpt_nxt   = 32'd0;
                w_long_nxt  = 1'b0;
            end
        endcase
    end

    assign o_sw_lvl  = r_stable;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;
    assign o_step    = r_step;

endmodule
`default_nettype wire

// File: tb/tb_sw_event_gen.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module : tb_sw_event_gen                                                    |
// | Brief  : Scoreboard bench for sw_event_gen with directed timed events.      |
// | Rev    : 1.0  initial release                                               |
// +-----------------------------------------------------------------------------+
module tb_sw_event_gen;

    localparam int DEB_CNT  = 4;
    localparam int LONG_CNT = 20;
    localparam int RPT_CNT  = 5;

    logic clk = 1'b0;
    logic rst_n;
    logic i_sw;
    logic o_sw_lvl;
    logic o_press;
    logic o_release;
    logic o_long;
    logic o_step;

    sw_event_gen #(
        .DEB_CNT    (DEB_CNT),
        .LONG_CNT   (LONG_CNT),
        .RPT_CNT    (RPT_CNT),
        .SW_ACT_LOW (1'b1)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_sw      (i_sw),
        .o_sw_lvl  (o_sw_lvl),
        .o_press   (o_press),
        .o_release (o_release),
        .o_long    (o_long),
        .o_step    (o_step)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected output tuple after the edge: {lvl, press, release, step, long}
    typedef struct {
        int         at;
        logic [4:0] val;
        string      name;
    } ev_t;

    ev_t  exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    logic prev_lvl  = 1'b0;
    logic prev_long = 1'b0;
    int   c;
    int   p;

    localparam logic [4:0] EV_PRESS   = 5'b11010;
    localparam logic [4:0] EV_LONG    = 5'b10011;
    localparam logic [4:0] EV_RPT     = 5'b10011;
    localparam logic [4:0] EV_RELEASE = 5'b00100;

    task automatic expect_ev(input string name, input int at, input logic [4:0] val);
        ev_t e;
        e.at   = at;
        e.val  = val;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: any pulse or level change is an output event popped against the queue.
    initial begin
        logic [4:0] got;
        ev_t        e;
        forever begin
            @(posedge clk);
            #1;
            got = {o_sw_lvl, o_press, o_release, o_step, o_long};
            if (!rst_n) begin
                n_chk++;
                if (got == 5'b00000) n_pass++;
                else $display("FAIL reset_outputs cyc=%0d got=%b want=00000", cyc, got);
                prev_lvl  = 1'b0;
                prev_long = 1'b0;
            end else if (o_press || o_release || o_step ||
                         (o_sw_lvl != prev_lvl) || (o_long != prev_long)) begin
                n_chk++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_event cyc=%0d got=%b want=no_event", cyc, got);
                end else begin
                    e = exp_q.pop_front();
                    if (e.at == cyc && e.val == got) n_pass++;
                    else $display("FAIL %s got cyc=%0d lvl/press/rel/step/long=%b want cyc=%0d %b",
                                  e.name, cyc, got, e.at, e.val);
                end
                prev_lvl  = o_sw_lvl;
                prev_long = o_long;
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        i_sw  = 1'b1;
        // Reset held for three edges with the raw input toggling.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            i_sw = ~i_sw;
        end
        @(negedge clk);
        rst_n = 1'b1;
        i_sw  = 1'b1;
        wait_neg(10);

        // Clean short press then release.
        c = cyc;
        i_sw = 1'b0;
        expect_ev("clean_press", c + 6, EV_PRESS);
        wait_neg(10);
        i_sw = 1'b1;
        expect_ev("clean_release", c + 16, EV_RELEASE);
        wait_neg(12);

        // Three-cycle glitch must vanish.
        i_sw = 1'b0;
        wait_neg(3);
        i_sw = 1'b1;
        wait_neg(10);

        // Four-cycle pulse is just long enough to be accepted.
        c = cyc;
        i_sw = 1'b0;
        expect_ev("pulse4_press", c + 6, EV_PRESS);
        wait_neg(4);
        i_sw = 1'b1;
        expect_ev("pulse4_release", c + 10, EV_RELEASE);
        wait_neg(12);

        // Long press with auto-repeat, released between repeats.
        c = cyc;
        p = c + 6;
        i_sw = 1'b0;
        expect_ev("long_press", p, EV_PRESS);
        expect_ev("long_point", p + 20, EV_LONG);
        expect_ev("repeat_1", p + 25, EV_RPT);
        expect_ev("repeat_2", p + 30, EV_RPT);
        wait_neg(32);
        i_sw = 1'b1;
        expect_ev("long_release", p + 32, EV_RELEASE);
        wait_neg(15);

        // Release accepted exactly on a repeat boundary.
        c = cyc;
        p = c + 6;
        i_sw = 1'b0;
        expect_ev("bnd_press", p, EV_PRESS);
        expect_ev("bnd_long", p + 20, EV_LONG);
        wait_neg(25);
        i_sw = 1'b1;
        expect_ev("bnd_release_no_step", p + 25, EV_RELEASE);
        wait_neg(15);

        // Reset mid-hold while the button stays pressed.
        c = cyc;
        p = c + 6;
        i_sw = 1'b0;
        expect_ev("rst_press", p, EV_PRESS);
        expect_ev("rst_long", p + 20, EV_LONG);
        wait_neg(27);
        rst_n = 1'b0;
        wait_neg(2);
        rst_n = 1'b1;
        expect_ev("post_rst_press", p + 29, EV_PRESS);
        expect_ev("post_rst_long", p + 49, EV_LONG);
        expect_ev("post_rst_repeat", p + 54, EV_RPT);
        wait_neg(28);
        i_sw = 1'b1;
        expect_ev("post_rst_release", p + 57, EV_RELEASE);
        wait_neg(20);

        n_chk++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL missing_events got=%0d_pending want=0 next=%s", exp_q.size(), exp_q[0].name);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
